// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: 4-digit multiplexed 7-seg driver with PWM dimming, dead time and tear-free loads
module seven_seg_scan_controller #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int DEAD_TICKS      = 1000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] load_v3,
    input  logic [3:0] load_v2,
    input  logic [3:0] load_v1,
    input  logic [3:0] load_v0,
    input  logic [3:0] load_dp,
    input  logic [3:0] digit_en,
    input  logic       lz_blank,
    input  logic [3:0] brightness,
    output logic [3:0] anodes,
    output logic [7:0] cathodes,
    output logic       frame_start
);
    localparam int TW = $clog2(TICKS_PER_DIGIT);
    localparam int SL = TICKS_PER_DIGIT / 16;
    // active-high a..g glyphs, entry 15 in the top bits
    localparam logic [111:0] SEG = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    typedef enum logic [1:0] {DEAD, ON, OFF} slot_t;

    slot_t           state, state_nxt;
    logic [TW-1:0]   tick, tick_nxt;
    logic [1:0]      idx;
    logic [3:0]      level, lvl;
    logic [3:0][3:0] val, shadow_val;
    logic [3:0]      dp, shadow_dp, zero, lead, blank;
    logic            pending, wrap, xfer, lit;

    assign load_ready = !pending;
    assign lead = {zero[3], &zero[3:2], &zero[3:1], 1'b0};
    assign blank = ~digit_en | ({4{lz_blank}} & lead);
    assign lit = state == ON && !blank[idx];

    always_comb begin
        tick_nxt = (tick == TW'(TICKS_PER_DIGIT - 1)) ? '0 : tick + 1'b1;
        wrap = tick_nxt == '0 && idx == 2'd3;
        xfer = load_valid && load_ready;
        lvl = (tick == '0) ? brightness : level;
        state_nxt = (tick_nxt < TW'(DEAD_TICKS)) ? DEAD :
                    (tick_nxt / TW'(SL) <= TW'(lvl)) ? ON : OFF;
        for (int i = 0; i < 4; i++) zero[i] = val[i] == 4'd0 && !dp[i];
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            tick <= '0;
            idx <= '0;
            state <= DEAD;
            level <= '0;
            val <= '0;
            dp <= '0;
            shadow_val <= '0;
            shadow_dp <= '0;
            pending <= 1'b0;
            anodes <= 4'hF;
            cathodes <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            tick <= tick_nxt;
            state <= state_nxt;
            level <= lvl;
            if (tick_nxt == '0) idx <= idx + 2'd1;
            // a load accepted on the wrap cycle itself waits for the following wrap
            if (wrap && pending) begin
                val <= shadow_val;
                dp <= shadow_dp;
            end
            if (xfer) begin
                shadow_val <= {load_v3, load_v2, load_v1, load_v0};
                shadow_dp <= load_dp;
            end
            pending <= xfer || (pending && !wrap);
            frame_start <= tick == '0 && idx == 2'd0;
            anodes <= lit ? ~(4'b1 << idx) : 4'hF;
            cathodes <= lit ? ~{dp[idx], SEG[7 * val[idx] +: 7]} : 8'hFF;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller: directed + random stimulus against a cycle-count based reference model
module tb_seven_seg_scan_controller;
    localparam int T = 32;
    localparam int DT = 1;
    localparam int SL = T / 16;
    localparam int F = 4 * T;

    logic        clk = 0, reset = 1, load_valid = 0, lz_blank = 0;
    logic        load_ready, frame_start;
    logic [15:0] vals = '0;
    logic [3:0]  load_dp = '0, digit_en = 4'hF, brightness = 4'd15, anodes;
    logic [7:0]  cathodes;
    int          vectors = 0, errors = 0;

    int              c, pend_frame;
    logic [3:0][3:0] m_val, p_val;
    logic [3:0]      m_dp, p_dp, slot_b, exp_an;
    logic [7:0]      exp_ca;
    logic            exp_fs;
    string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    always #5 clk = ~clk;

    seven_seg_scan_controller #(.TICKS_PER_DIGIT(T), .DEAD_TICKS(DT)) dut (
        .clk_100MHz(clk),
        .reset(reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_v3(vals[15:12]),
        .load_v2(vals[11:8]),
        .load_v1(vals[7:4]),
        .load_v0(vals[3:0]),
        .load_dp(load_dp),
        .digit_en(digit_en),
        .lz_blank(lz_blank),
        .brightness(brightness),
        .anodes(anodes),
        .cathodes(cathodes),
        .frame_start(frame_start)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, c);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] v);
        seg = '0;
        for (int i = 0; i < glyph[v].len(); i++) seg[int'(glyph[v].getc(i)) - 97] = 1'b1;
    endfunction

    function automatic logic blanked(input int d);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = d; j < 4; j++) if (m_val[j] != 4'd0 || m_dp[j]) all_zero = 1'b0;
        return !digit_en[d] || (lz_blank && d > 0 && all_zero);
    endfunction

    // check this cycle, predict next cycle's registered outputs, then advance one clock
    task automatic step();
        int t, d;
        check("anodes", anodes, exp_an);
        check("cathodes", cathodes, exp_ca);
        check("frame_start", frame_start, exp_fs);
        check("load_ready", load_ready, pend_frame < 0);
        t = c % T;
        d = (c / T) % 4;
        if (t == 0) slot_b = brightness;
        exp_fs = c % F == 0;
        exp_an = 4'hF;
        exp_ca = 8'hFF;
        if (t >= DT && t / SL <= slot_b && !blanked(d)) begin
            exp_an[d] = 1'b0;
            exp_ca = ~{m_dp[d], seg(m_val[d])};
        end
        if (load_valid && pend_frame < 0) begin
            p_val = vals;
            p_dp = load_dp;
            pend_frame = c / F + ((c % F == F - 1) ? 2 : 1);
        end
        c++;
        if (c % F == 0 && c / F == pend_frame) begin
            m_val = p_val;
            m_dp = p_dp;
            pend_frame = -1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_anodes", anodes, 4'hF);
            check("rst_cathodes", cathodes, 8'hFF);
            check("rst_load_ready", load_ready, 1'b1);
            check("rst_frame_start", frame_start, 1'b0);
        end
        @(negedge clk);
        reset = 0;
        c = 0;
        pend_frame = -1;
        m_val = '0;
        m_dp = '0;
        exp_an = 4'hF;
        exp_ca = 8'hFF;
        exp_fs = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] p);
        load_valid = 1;
        vals = v;
        load_dp = p;
        step();
        load_valid = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(3);
        run(F + 40);
        load(16'h1234, 4'h0);
        run(2 * F);
        brightness = 4'd3;
        run(F);
        lz_blank = 1;
        load(16'h0005, 4'h0);
        run(2 * F);
        load(16'h0005, 4'b0100);
        run(2 * F);
        while (c % F != F - 1) step();
        load(16'hABCD, 4'b1010);
        load(16'h9876, 4'hF);
        run(3 * F);
        load(16'hE0F1, 4'h3);
        while (c % F != 2 * T + 4) step();
        do_reset(1);
        run(F + 8);
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 15) == 0) digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            load_valid = $urandom_range(0, 7) == 0;
            for (int i = 0; i < 4; i++) vals[i * 4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            load_dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 999) == 0) do_reset(2);
            step();
        end
        load_valid = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
